uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  UART receive control block, the receive-side partner of the UART transmit block in the UART peripheral.
//  Synchronises the UART_RX pin and samples it at 16x baud with mid-bit sampling.
//  Deframes start/data/parity/stop (LSB first) and pushes each good byte into a receive FIFO.
//  Reports parity, framing and overrun errors to the UART register block as sticky flags.
// PARAMETERS
//  UART_DATA_WIDTH        8  FIFO entry width; fixed at 8
//  UART_RX_FIFO_DEPTH     8  receive FIFO entries (power of 2)
//  UART_RX_FIFO_PTR_WIDTH $clog2(UART_RX_FIFO_DEPTH)  FIFO pointer width
// PORTS
//  ACLK              in   1  clock; the only clock in this block
//  ARESETn           in   1  reset; asynchronous assert, active-low
//  rx_sample_pulse   in   1  one-ACLK-cycle strobe at 16x baud rate
//  UART_RX           in   1  serial input pin; asynchronous to ACLK; idles high
//  data_bits         in   1  0 = 7 data bits, 1 = 8 data bits
//  parity_en         in   1  1 = a parity bit follows the data bits
//  parity_odd0_even1 in   1  0 = odd parity, 1 = even parity
//  rx_data_rd        in   1  pop strobe; pops the FIFO head when rx_data_valid is 1
//  err_clr           in   1  clears all three sticky error flags
//  rx_data           out  8  FIFO head; valid only while rx_data_valid is 1
//  rx_data_valid     out  1  FIFO not empty
//  rx_full           out  1  FIFO full
//  parity_err        out  1  sticky: a byte was received with a bad parity bit
//  frame_err         out  1  sticky: a stop bit was sampled as 0
//  overrun_err       out  1  sticky: a good byte arrived while the FIFO was full
// BEHAVIOUR
//  Reset values: FIFO empty, rx_data_valid=0, rx_full=0, all error flags 0, FSM in IDLE.
//   Both synchroniser flops reset to 1.
//  Input path: UART_RX passes through a 2-flop synchroniser to give rxs.
//   Start-edge detection uses a third flop holding the previous value of rxs.
//  Timing: a 4-bit sample counter advances only on rx_sample_pulse.
//   Data, parity and stop bits are sampled when the counter wraps (every 16 pulses).
//  FSM states: IDLE, START, DATA, PARITY, STOP.
//   IDLE -> START: on a falling edge of rxs (previous 1, current 0). The sample counter clears.
//   START: on the 8th pulse (mid start bit), go to DATA if rxs=0 and clear the counter;
//    otherwise go back to IDLE (glitch rejected, nothing reported).
//   DATA: shift in 7+data_bits bits, LSB first, one per 16 pulses.
//    A 3-bit bit counter runs 0..(6+data_bits).
//    After the last bit go to PARITY if parity_en=1, else to STOP.
//    In 7-bit mode, stored bit7 = 0.
//   PARITY: sample one bit. It is good if
//    (^data8 ^ pbit) == 0 for even parity,
//    or (^data8 ^ pbit) == 1 for odd parity,
//    where data8 is the stored 8-bit value.
//   STOP: sample at mid-bit, then return to IDLE in the same cycle.
//  Byte disposition, decided at the stop sample:
//   stop=1: byte is pushed to the FIFO. If parity was bad, the byte is still pushed and parity_err sets.
//   stop=0: byte is discarded and frame_err sets. IDLE then waits for rxs=1 before
//    re-arming edge detection, so a break condition produces exactly one frame_err.
//   FIFO full at the push: byte is dropped, overrun_err sets, FIFO contents are unchanged.
//  Latency: a pushed byte appears on rx_data / rx_data_valid in the ACLK cycle after the stop sample.
//  Simultaneous push and pop: the pop happens first, so a full FIFO with a pop in the same cycle accepts the push (no overrun).
//  rx_data_rd while the FIFO is empty is ignored.
//  Pointer wrap-around: natural modulo UART_RX_FIFO_DEPTH, with full/empty detected by the extra pointer bit.
//  Sticky flags: set has priority over err_clr in the same cycle.
//  Config inputs (data_bits, parity_en, parity_odd0_even1) must be static during a frame.
//   Changes mid-frame give undefined data but must not hang the FSM.
//   Every state exits within 11 bit periods.
//  Reset asserted mid-frame: all state returns to reset values immediately, including FIFO contents.
// TESTING
//  T1: 8N1, rx_sample_pulse every 4 ACLK cycles, send 0xA5 -> rx_data=0xA5, rx_data_valid=1, no error flags.
//  T2: 7E1, send 0x41 with parity bit 0, then 0x43 with parity bit 0 (bad)
//      -> both bytes are read out; parity_err=1 only after the second byte.
//  T3: 8N1, drive 0x55 with the stop bit held at 0
//      -> FIFO stays empty, frame_err=1; line held low for 3 frames -> still a single frame_err.
//  T4: send 9 bytes 0x00..0x08 with no pops -> rx_full=1, overrun_err=1,
//      reading out returns 0x00..0x07, then rx_data_valid=0.
//  T5: 1-pulse low glitch on UART_RX in IDLE -> no byte, no flags, FSM back in IDLE.
//      Then a pop in the same cycle as the push of byte 9 -> no overrun.
//  T6: assert ARESETn=0 mid-DATA of 0x3C, then release and send 0x81
//      -> only 0x81 is received, all flags 0.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchroniser, 16x oversampled start/data/parity/stop
// deframing, an 8-entry receive FIFO and sticky parity/framing/overrun flags.
module uart_rx #(
  parameter int UART_DATA_WIDTH        = 8,
  parameter int UART_RX_FIFO_DEPTH     = 8,
  parameter int UART_RX_FIFO_PTR_WIDTH = $clog2(UART_RX_FIFO_DEPTH)
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic                       rx_sample_pulse,
  input  logic                       UART_RX,
  input  logic                       data_bits,
  input  logic                       parity_en,
  input  logic                       parity_odd0_even1,
  input  logic                       rx_data_rd,
  input  logic                       err_clr,
  output logic [UART_DATA_WIDTH-1:0] rx_data,
  output logic                       rx_data_valid,
  output logic                       rx_full,
  output logic                       parity_err,
  output logic                       frame_err,
  output logic                       overrun_err
);

  localparam int PW = UART_RX_FIFO_PTR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                     state_q, state_d;
  logic [1:0]                 sync_q;
  logic                       prev_q;
  logic                       rxs;
  logic [3:0]                 cnt_q, cnt_d;
  logic [2:0]                 bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_WIDTH-1:0] data_q, data_d;
  logic                       par_bad_q, par_bad_d;
  logic                       armed_q, armed_d;
  logic                       parity_err_q, parity_err_d;
  logic                       frame_err_q, frame_err_d;
  logic                       overrun_err_q, overrun_err_d;
  logic [PW:0]                wr_ptr_q, wr_ptr_d;
  logic [PW:0]                rd_ptr_q, rd_ptr_d;
  logic [UART_DATA_WIDTH-1:0] mem_q [UART_RX_FIFO_DEPTH];

  logic wrap;
  logic push_req;
  logic par_set;
  logic frm_set;
  logic ovr_set;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;

  assign rxs  = sync_q[1];
  assign wrap = rx_sample_pulse && (cnt_q == 4'hF);

  // Synchroniser and edge-detect history idle high so reset never looks like a start edge.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], UART_RX};
      prev_q <= sync_q[1];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      bit_cnt_q     <= 3'd0;
      data_q        <= '0;
      par_bad_q     <= 1'b0;
      armed_q       <= 1'b1;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      data_q        <= data_d;
      par_bad_q     <= par_bad_d;
      armed_q       <= armed_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    par_bad_d = par_bad_q;
    armed_d   = armed_q;
    push_req  = 1'b0;
    par_set   = 1'b0;
    frm_set   = 1'b0;
    if (rx_sample_pulse) begin
      cnt_d = cnt_q + 4'd1;
    end
    case (state_q)
      S_IDLE: begin
        // After a bad stop bit the line must return high before a new start is accepted.
        if (!armed_q) begin
          if (rxs) begin
            armed_d = 1'b1;
          end
        end else if (prev_q && !rxs) begin
          state_d = S_START;
          cnt_d   = 4'd0;
        end
      end
      S_START: begin
        if (rx_sample_pulse && (cnt_q == 4'd7)) begin
          if (!rxs) begin
            state_d   = S_DATA;
            cnt_d     = 4'd0;
            bit_cnt_d = 3'd0;
            data_d    = '0;
            par_bad_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (wrap) begin
          data_d[bit_cnt_q] = rxs;
          bit_cnt_d         = bit_cnt_q + 3'd1;
          // >= keeps the state bounded even if data_bits flips mid-frame.
          if (bit_cnt_q >= {2'b11, data_bits}) begin
            state_d = parity_en ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (wrap) begin
          par_bad_d = (^data_q) ^ rxs ^ ~parity_odd0_even1;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (wrap) begin
          state_d = S_IDLE;
          if (rxs) begin
            push_req = 1'b1;
            par_set  = par_bad_q;
          end else begin
            frm_set = 1'b1;
            armed_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pop is resolved before push, so a full FIFO being read this cycle still accepts a byte.
  always_comb begin
    fifo_empty    = (wr_ptr_q == rd_ptr_q);
    fifo_full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    pop           = rx_data_rd && !fifo_empty;
    push          = push_req && (!fifo_full || pop);
    ovr_set       = push_req && fifo_full && !pop;
    rd_ptr_d      = rd_ptr_q + {{PW{1'b0}}, pop};
    wr_ptr_d      = wr_ptr_q + {{PW{1'b0}}, push};
    parity_err_d  = par_set | (parity_err_q & ~err_clr);
    frame_err_d   = frm_set | (frame_err_q & ~err_clr);
    overrun_err_d = ovr_set | (overrun_err_q & ~err_clr);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < UART_RX_FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q[PW-1:0]] <= data_q;
    end
  end

  assign rx_data       = mem_q[rd_ptr_q[PW-1:0]];
  assign rx_data_valid = !fifo_empty;
  assign rx_full       = fifo_full;
  assign parity_err    = parity_err_q;
  assign frame_err     = frame_err_q;
  assign overrun_err   = overrun_err_q;

endmodule
